// File: rtl/reg_access_master.sv
// Command-driven initiator for a registers-style storage target: write, read,
// write-then-verify. Optional saturating error counter behind REG_ACCESS_ERRCNT_EN.
module reg_access_master #(
  parameter int N      = 6,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_data,
  output logic         reg_write,
  output logic         reg_read,
  output logic [N-1:0] reg_din,
  input  logic [N-1:0] reg_dout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_err
`ifdef REG_ACCESS_ERRCNT_EN
  ,
  output logic [7:0]   err_count
`endif
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_VFY = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [2:0]   state_reg, state_next;
  logic [1:0]   op_reg;
  logic [3:0]   cnt_reg;
  logic [N-1:0] din_reg;
  logic [N-1:0] rsp_data_reg;
  logic         rsp_err_reg;
  logic         alive_reg;
  logic         accept;
  logic         rsp_fire;

  // alive_reg keeps cmd_ready low while in reset even though the state is IDLE
  assign cmd_ready = alive_reg && (state_reg == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign reg_write = (state_reg == WR);
  assign reg_read  = (state_reg == RD);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign reg_din   = din_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_RD:   state_next = RD;
            OP_RSV:  state_next = RESP;
            default: state_next = WR;
          endcase
        end
      end
      WR:      state_next = (op_reg == OP_VFY) ? RD : RESP;
      RD:      state_next = WAIT;
      WAIT:    if (cnt_reg == 4'd1) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      op_reg       <= OP_WR;
      cnt_reg      <= 4'd0;
      din_reg      <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
      alive_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      alive_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg <= cmd_op;
            // read commands leave reg_din holding the last written value
            if (cmd_op == OP_WR || cmd_op == OP_VFY) begin
              din_reg <= cmd_data;
            end
            if (cmd_op == OP_RSV) begin
              rsp_data_reg <= '0;
              rsp_err_reg  <= 1'b1;
            end
          end
        end
        WR: begin
          if (op_reg == OP_WR) begin
            rsp_data_reg <= din_reg;
            rsp_err_reg  <= 1'b0;
          end
        end
        RD: begin
          cnt_reg <= 4'(RD_LAT);
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            rsp_data_reg <= reg_dout;
            rsp_err_reg  <= (op_reg == OP_VFY) && (reg_dout != din_reg);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef REG_ACCESS_ERRCNT_EN
  logic [7:0] err_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count_reg <= 8'd0;
    end else if (rsp_fire && rsp_err_reg && err_count_reg != 8'hFF) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign err_count = err_count_reg;
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
`endif

endmodule
